// File: rtl/spi_ram_slave_burst_if.sv
// SPI pin bundle between an external master and the RAM slave.
interface spi_ram_slave_burst_if;
  logic ss_n;
  logic mosi;
  logic miso;
  logic busy;
  logic frame_err;

  modport master (output ss_n, mosi, input miso, busy, frame_err);
  modport slave  (input ss_n, mosi, output miso, busy, frame_err);
endinterface

// File: rtl/spi_ram_slave_burst.sv
// SPI slave on a single-port RAM: opcode-driven address/data frames with burst
// auto-increment, gapless read streaming and a frame-abort error pulse.
module spi_ram_slave_burst #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned AUTO_INC  = 1,
  parameter int unsigned RD_TURN   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_ram_slave_burst_if.slave spi
);
  localparam int unsigned MAXW   = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int unsigned CNTMAX = (MAXW > RD_TURN) ? MAXW : RD_TURN;
  localparam int unsigned CW     = $clog2(CNTMAX + 1);
  localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);
  localparam int unsigned SHW    = MAXW - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WADDR, S_WDATA, S_RADDR, S_RTURN, S_RDATA
  } state_t;

  state_t            state, state_nxt;
  logic              err_nxt;
  logic [CW-1:0]     cnt;
  logic              op0;
  logic              done;
  logic              wr_pend;
  logic [SHW-1:0]    shreg;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] wr_word, rd_word, nxt_word;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Pointers wrap at the physical depth, not at the address-field range.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(MEM_DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  function automatic logic [MEM_AW-1:0] midx(input logic [ADDR_W-1:0] p);
    return MEM_AW'(p);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    if (spi.ss_n) begin
      state_nxt = S_IDLE;
      case (state)
        S_CMD:            err_nxt = 1'b1;
        S_WADDR, S_RADDR: err_nxt = (cnt != '0);
        S_WDATA:          err_nxt = (cnt != '0) && !done;
        default:          err_nxt = 1'b0;
      endcase
    end else begin
      case (state)
        S_IDLE: state_nxt = S_CMD;
        S_CMD: begin
          if (cnt[0]) begin
            case ({op0, spi.mosi})
              2'b00:   state_nxt = S_WADDR;
              2'b01:   state_nxt = S_WDATA;
              2'b10:   state_nxt = S_RADDR;
              default: state_nxt = S_RTURN;
            endcase
          end
        end
        S_RTURN: if (cnt == CW'(RD_TURN - 1)) state_nxt = S_RDATA;
        default: ;
      endcase
    end
  end

  // Shifting, pointers and registered pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      op0           <= 1'b0;
      done          <= 1'b0;
      wr_pend       <= 1'b0;
      shreg         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      wr_word       <= '0;
      rd_word       <= '0;
      nxt_word      <= '0;
      spi.miso      <= 1'b0;
      spi.busy      <= 1'b0;
      spi.frame_err <= 1'b0;
    end else begin
      spi.busy      <= (state_nxt != S_IDLE);
      spi.frame_err <= err_nxt;
      spi.miso      <= 1'b0;
      wr_pend       <= 1'b0;
      if (wr_pend && (AUTO_INC != 0)) wr_ptr <= ptr_inc(wr_ptr);
      if (spi.ss_n) begin
        cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt  <= '0;
            done <= 1'b0;
          end
          S_CMD: begin
            op0 <= spi.mosi;
            cnt <= cnt[0] ? '0 : cnt + CW'(1);
          end
          S_WADDR, S_RADDR: begin
            shreg <= SHW'({shreg, spi.mosi});
            if (cnt == CW'(ADDR_W - 1)) begin
              cnt <= '0;
              if (!done) begin
                done <= 1'b1;
                if (state == S_WADDR) wr_ptr <= {shreg[ADDR_W-2:0], spi.mosi};
                else                  rd_ptr <= {shreg[ADDR_W-2:0], spi.mosi};
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_WDATA: begin
            if (!done) begin
              shreg <= SHW'({shreg, spi.mosi});
              if (cnt == CW'(DATA_W - 1)) begin
                cnt     <= '0;
                wr_pend <= 1'b1;
                wr_word <= {shreg[DATA_W-2:0], spi.mosi};
                if (AUTO_INC == 0) done <= 1'b1;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          S_RTURN: begin
            if (cnt == '0) rd_word <= mem[midx(rd_ptr)];
            cnt <= (cnt == CW'(RD_TURN - 1)) ? '0 : cnt + CW'(1);
          end
          S_RDATA: begin
            if (!done) begin
              spi.miso <= rd_word[DATA_W-1];
              rd_word  <= {rd_word[DATA_W-2:0], 1'b0};
              nxt_word <= mem[midx(ptr_inc(rd_ptr))];
              if (cnt == CW'(DATA_W - 1)) begin
                cnt <= '0;
                if (AUTO_INC != 0) begin
                  rd_word <= nxt_word;
                  rd_ptr  <= ptr_inc(rd_ptr);
                end else begin
                  done <= 1'b1;
                end
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // RAM array has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_pend) mem[midx(wr_ptr)] <= wr_word;
  end
endmodule

// File: tb/tb_spi_ram_slave_burst.sv
// Directed bench: three DUT flavours (burst/256, burst/200-deep, legacy) share one SPI stimulus.
module tb_spi_ram_slave_burst;
  localparam int unsigned RT = 2;

  logic clk = 1'b0;
  logic rst;
  logic ss_n;
  logic mosi;

  int n_tests = 0;
  int n_fail  = 0;

  logic       err1, err2, turn_ok;
  logic [7:0] rx0 [4];
  logic [7:0] rx1 [4];
  logic [7:0] rx2 [4];

  spi_ram_slave_burst_if bus0 ();
  spi_ram_slave_burst_if bus1 ();
  spi_ram_slave_burst_if bus2 ();

  assign bus0.ss_n = ss_n;
  assign bus0.mosi = mosi;
  assign bus1.ss_n = ss_n;
  assign bus1.mosi = mosi;
  assign bus2.ss_n = ss_n;
  assign bus2.mosi = mosi;

  spi_ram_slave_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1), .RD_TURN(RT))
    dut (.clk(clk), .rst(rst), .spi(bus0.slave));
  spi_ram_slave_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1), .RD_TURN(RT))
    dut_w (.clk(clk), .rst(rst), .spi(bus1.slave));
  spi_ram_slave_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(0), .RD_TURN(RT))
    dut_l (.clk(clk), .rst(rst), .spi(bus2.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      tick();
    end
  endtask

  task automatic start_frame();
    ss_n = 1'b0;
    mosi = 1'b0;
    tick();
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    mosi = 1'b0;
    tick();
    err1 = bus0.frame_err;
    tick();
    err2 = bus0.frame_err;
  endtask

  task automatic addr_frame(input logic [15:0] op, input logic [15:0] a);
    start_frame();
    send_bits(op, 2);
    send_bits(a, 8);
    end_frame();
  endtask

  task automatic wr_frame(input logic [31:0] data, input int nw);
    start_frame();
    send_bits(16'h1, 2);
    for (int k = 0; k < nw; k++) send_bits(16'(data[8*(nw-1-k) +: 8]), 8);
    end_frame();
  endtask

  task automatic read_frame(input int nw);
    start_frame();
    send_bits(16'h3, 2);
    turn_ok = 1'b1;
    repeat (RT) begin
      tick();
      if (bus0.miso !== 1'b0) turn_ok = 1'b0;
    end
    for (int w = 0; w < nw; w++) begin
      for (int b = 7; b >= 0; b--) begin
        tick();
        rx0[w][b] = bus0.miso;
        rx1[w][b] = bus1.miso;
        rx2[w][b] = bus2.miso;
      end
    end
    end_frame();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bus0.miso, bus0.busy, bus0.frame_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000", {bus0.miso, bus0.busy, bus0.frame_err});
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (bus0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: got %b expected 0", bus0.busy);
    end
  endtask

  task automatic test_burst_write();
    addr_frame(16'h0, 16'h10);
    start_frame();
    n_tests++;
    if (bus0.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_frame: got %b expected 1", bus0.busy);
    end
    send_bits(16'h1, 2);
    send_bits(16'hA5, 8);
    send_bits(16'h3C, 8);
    send_bits(16'h7E, 8);
    end_frame();
    n_tests++;
    if (err1 !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_end_no_err: got %b expected 0", err1);
    end
    n_tests++;
    if (bus0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_frame: got %b expected 0", bus0.busy);
    end
    // no address: lands at the stored pointer 0x13
    wr_frame(32'h99, 1);
  endtask

  task automatic test_burst_read();
    logic [7:0] exp_w [4];
    exp_w[0] = 8'hA5; exp_w[1] = 8'h3C; exp_w[2] = 8'h7E; exp_w[3] = 8'h99;
    addr_frame(16'h2, 16'h10);
    read_frame(4);
    n_tests++;
    if (turn_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL turnaround_miso_low: got %b expected 1", turn_ok);
    end
    for (int w = 0; w < 4; w++) begin
      n_tests++;
      if (rx0[w] !== exp_w[w]) begin
        n_fail++;
        $display("FAIL burst_read_w%0d: got %h expected %h", w, rx0[w], exp_w[w]);
      end
    end
  endtask

  task automatic test_wrap();
    addr_frame(16'h0, 16'd199);
    wr_frame(32'h1122, 2);
    addr_frame(16'h2, 16'd199);
    read_frame(2);
    n_tests++;
    if (rx1[0] !== 8'h11) begin
      n_fail++;
      $display("FAIL wrap_ram199: got %h expected 11", rx1[0]);
    end
    n_tests++;
    if (rx1[1] !== 8'h22) begin
      n_fail++;
      $display("FAIL wrap_ram0: got %h expected 22", rx1[1]);
    end
    n_tests++;
    if (rx0[1] !== 8'h22) begin
      n_fail++;
      $display("FAIL nowrap_ram200: got %h expected 22", rx0[1]);
    end
  endtask

  task automatic test_frame_err();
    addr_frame(16'h0, 16'h40);
    wr_frame(32'h55, 1);
    addr_frame(16'h0, 16'h40);
    start_frame();
    send_bits(16'h1, 2);
    send_bits(16'h16, 5);
    end_frame();
    n_tests++;
    if (err1 !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_word_err: got %b expected 1", err1);
    end
    n_tests++;
    if (err2 !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse_width: got %b expected 0", err2);
    end
    addr_frame(16'h2, 16'h40);
    read_frame(1);
    n_tests++;
    if (rx0[0] !== 8'h55) begin
      n_fail++;
      $display("FAIL partial_ram_unchanged: got %h expected 55", rx0[0]);
    end
    wr_frame(32'h66, 1);
    addr_frame(16'h2, 16'h40);
    read_frame(1);
    n_tests++;
    if (rx0[0] !== 8'h66) begin
      n_fail++;
      $display("FAIL partial_ptr_unchanged: got %h expected 66", rx0[0]);
    end
    start_frame();
    send_bits(16'h1, 1);
    end_frame();
    n_tests++;
    if (err1 !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_abort_err: got %b expected 1", err1);
    end
    start_frame();
    send_bits(16'h0, 2);
    send_bits(16'h5, 3);
    end_frame();
    n_tests++;
    if (err1 !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_abort_err: got %b expected 1", err1);
    end
    start_frame();
    send_bits(16'h3, 2);
    repeat (RT + 3) tick();
    end_frame();
    n_tests++;
    if (err1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rdata_abort_no_err: got %b expected 0", err1);
    end
  endtask

  task automatic test_legacy();
    addr_frame(16'h0, 16'h20);
    wr_frame(32'h5AFF, 2);
    addr_frame(16'h2, 16'h20);
    read_frame(2);
    n_tests++;
    if (rx2[0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL legacy_word: got %h expected 5a", rx2[0]);
    end
    n_tests++;
    if (rx2[1] !== 8'h00) begin
      n_fail++;
      $display("FAIL legacy_miso_idle: got %h expected 00", rx2[1]);
    end
    n_tests++;
    if (rx0[1] !== 8'hFF) begin
      n_fail++;
      $display("FAIL burst_second_word: got %h expected ff", rx0[1]);
    end
  endtask

  task automatic test_reset_mid_frame();
    // in-flight write whose commit edge never arrives
    addr_frame(16'h0, 16'h30);
    wr_frame(32'h77, 1);
    addr_frame(16'h0, 16'h30);
    start_frame();
    send_bits(16'h1, 2);
    send_bits(16'h88, 8);
    n_tests++;
    if (bus0.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_before_rst: got %b expected 1", bus0.busy);
    end
    #3 rst = 1'b1;
    ss_n = 1'b1;
    #1;
    n_tests++;
    if ({bus0.miso, bus0.busy, bus0.frame_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid_write: got %b expected 000", {bus0.miso, bus0.busy, bus0.frame_err});
    end
    #2 rst = 1'b0;
    tick();
    addr_frame(16'h2, 16'h30);
    read_frame(1);
    n_tests++;
    if (rx0[0] !== 8'h77) begin
      n_fail++;
      $display("FAIL write_dropped: got %h expected 77", rx0[0]);
    end
    // reset while streaming read data
    addr_frame(16'h2, 16'h10);
    start_frame();
    send_bits(16'h3, 2);
    repeat (RT + 1) tick();
    n_tests++;
    if (bus0.miso !== 1'b1) begin
      n_fail++;
      $display("FAIL miso_msb_before_rst: got %b expected 1", bus0.miso);
    end
    #3 rst = 1'b1;
    ss_n = 1'b1;
    #1;
    n_tests++;
    if ({bus0.miso, bus0.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_mid_read: got %b expected 00", {bus0.miso, bus0.busy});
    end
    #2 rst = 1'b0;
    tick();
    read_frame(1);
    n_tests++;
    if (rx1[0] !== 8'h22) begin
      n_fail++;
      $display("FAIL rd_ptr_reset: got %h expected 22", rx1[0]);
    end
    addr_frame(16'h2, 16'h10);
    read_frame(1);
    n_tests++;
    if (rx0[0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL ram_retained: got %h expected a5", rx0[0]);
    end
  endtask

  initial begin
    test_reset();
    test_burst_write();
    test_burst_read();
    test_wrap();
    test_frame_err();
    test_legacy();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
